// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and status bit positions.
package alu_pkg;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,
    OP_ADD = 5'd1,
    OP_SUB = 5'd2,
    OP_AND = 5'd3,
    OP_OR  = 5'd4,
    OP_NOT = 5'd5,
    OP_XOR = 5'd6,
    OP_SHL = 5'd7,
    OP_SHR = 5'd8,
    OP_VAL = 5'd9,
    OP_CMP = 5'd10,
    OP_MUL = 5'd11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int StatusBits    = 6;
  localparam int FLAG_CARRY     = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_ZERO      = 2;
  localparam int FLAG_EQUAL     = 3;
  localparam int FLAG_GREATER   = 4;
  localparam int FLAG_SMALLER   = 5;

  function automatic logic is_shift(input logic [4:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_flags.sv
// Status word assembly: Zero and the unsigned compare flags, plus pass-through Carry/Underflow.
module alu_flags
  import alu_pkg::*;
#(
  parameter int DataWidth = 8
) (
  input  logic [DataWidth-1:0]  value,
  input  logic [DataWidth-1:0]  lhs,
  input  logic [DataWidth-1:0]  rhs,
  input  logic                  carry,
  input  logic                  underflow,
  input  logic                  zero_en,
  input  logic                  cmp_en,
  output logic [StatusBits-1:0] status
);

  // Zero is suppressed when a carry escaped, so 128+128 is not reported as zero.
  always_comb begin
    status                 = '0;
    status[FLAG_CARRY]     = carry;
    status[FLAG_UNDERFLOW] = underflow;
    status[FLAG_ZERO]      = zero_en && (value == '0) && !carry;
    status[FLAG_EQUAL]     = cmp_en && (lhs == rhs);
    status[FLAG_GREATER]   = cmp_en && (lhs > rhs);
    status[FLAG_SMALLER]   = cmp_en && (lhs < rhs);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts, optional shift-add multiply.
// Define ALU_MC_MUL_EN to build the MUL opcode; otherwise opcode 11 behaves as NOP.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int ParamBits = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [4:0]           opcode,
  input  logic [DataWidth-1:0] operand1,
  input  logic [DataWidth-1:0] operand2,
  input  logic [ParamBits-1:0] param,
  output logic                 busy,
  output logic                 done,
  output logic [DataWidth-1:0] result,
  output logic [5:0]           status
);

  localparam int CntBits = $clog2(DataWidth + 1);
  localparam logic [CntBits-1:0] CntFull = CntBits'(DataWidth);
  localparam logic [CntBits-1:0] CntOne  = CntBits'(1);

  state_e               state;
  logic [4:0]           op_q;
  logic [DataWidth-1:0] shreg;
  logic [CntBits-1:0]   cnt;

`ifdef ALU_MC_MUL_EN
  logic [2*DataWidth-1:0] acc;
  logic [2*DataWidth-1:0] mcand;
  logic [2*DataWidth-1:0] acc_next;
`endif

  logic [DataWidth:0]     sum;
  logic [DataWidth-1:0]   calc_res;
  logic                   calc_carry;
  logic                   calc_under;
  logic                   calc_zero_en;
  logic                   calc_cmp_en;
  logic [CntBits-1:0]     shift_len;
  logic [DataWidth-1:0]   shift_next;
  logic [DataWidth-1:0]   run_res;
  logic                   run_carry;
  logic                   in_idle;
  logic [DataWidth-1:0]   f_value;
  logic                   f_carry;
  logic                   f_under;
  logic                   f_zero_en;
  logic                   f_cmp_en;
  logic [StatusBits-1:0]  status_next;

  // Shifts longer than the word saturate at DataWidth steps, which drains the value to zero.
  assign shift_len = (int'(param) >= DataWidth) ? CntFull : CntBits'(param);

  // Single-cycle operations evaluate straight from the inputs on the accepting edge.
  always_comb begin
    calc_res     = '0;
    calc_carry   = 1'b0;
    calc_under   = 1'b0;
    calc_zero_en = 1'b1;
    calc_cmp_en  = 1'b0;
    sum          = {1'b0, operand1} + {1'b0, operand2};
    case (opcode)
      OP_ADD: begin
        calc_res    = sum[DataWidth-1:0];
        calc_carry  = sum[DataWidth];
        calc_cmp_en = 1'b1;
      end
      OP_SUB: begin
        calc_res    = operand1 - operand2;
        calc_under  = operand1 < operand2;
        calc_cmp_en = 1'b1;
      end
      OP_AND: begin
        calc_res    = operand1 & operand2;
        calc_cmp_en = 1'b1;
      end
      OP_OR: begin
        calc_res    = operand1 | operand2;
        calc_cmp_en = 1'b1;
      end
      OP_XOR: begin
        calc_res    = operand1 ^ operand2;
        calc_cmp_en = 1'b1;
      end
      OP_NOT:         calc_res = ~operand2;
      OP_SHL, OP_SHR: calc_res = operand1;
      OP_VAL:         calc_res = DataWidth'(param);
      OP_CMP: begin
        calc_zero_en = 1'b0;
        calc_cmp_en  = 1'b1;
      end
      default:        calc_zero_en = 1'b0;
    endcase
  end

  // One step of the running operation; the value produced on the final step is the result.
  always_comb begin
    shift_next = (op_q == OP_SHL) ? (shreg << 1) : (shreg >> 1);
    run_res    = shift_next;
    run_carry  = 1'b0;
`ifdef ALU_MC_MUL_EN
    acc_next = acc + (shreg[0] ? mcand : '0);
    if (op_q == OP_MUL) begin
      run_res   = acc_next[DataWidth-1:0];
      run_carry = |acc_next[2*DataWidth-1:DataWidth];
    end
`endif
  end

  assign in_idle   = (state == ST_IDLE);
  assign f_value   = in_idle ? calc_res : run_res;
  assign f_carry   = in_idle ? calc_carry : run_carry;
  assign f_under   = in_idle ? calc_under : 1'b0;
  assign f_zero_en = in_idle ? calc_zero_en : 1'b1;
  assign f_cmp_en  = in_idle ? calc_cmp_en : 1'b0;

  alu_flags #(
    .DataWidth(DataWidth)
  ) u_flags (
    .value    (f_value),
    .lhs      (operand1),
    .rhs      (operand2),
    .carry    (f_carry),
    .underflow(f_under),
    .zero_en  (f_zero_en),
    .cmp_en   (f_cmp_en),
    .status   (status_next)
  );

  // Control FSM; busy and done are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      status <= '0;
      op_q   <= '0;
      shreg  <= '0;
      cnt    <= '0;
`ifdef ALU_MC_MUL_EN
      acc    <= '0;
      mcand  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= opcode;
            shreg <= operand1;
            busy  <= 1'b1;
            if (is_shift(opcode) && (shift_len != '0)) begin
              cnt   <= shift_len;
              state <= ST_RUN;
            end
`ifdef ALU_MC_MUL_EN
            else if (opcode == OP_MUL) begin
              cnt   <= CntFull;
              shreg <= operand2;
              acc   <= '0;
              mcand <= {{DataWidth{1'b0}}, operand1};
              state <= ST_RUN;
            end
`endif
            else begin
              result <= calc_res;
              status <= status_next;
              done   <= 1'b1;
              state  <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          shreg <= shift_next;
          cnt   <= cnt - CntOne;
`ifdef ALU_MC_MUL_EN
          acc   <= acc_next;
          mcand <= mcand << 1;
`endif
          if (cnt == CntOne) begin
            result <= run_res;
            status <= status_next;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed vectors push expectations, a monitor checks every done pulse.
module tb_alu_mc;

  localparam logic [4:0] OpNop = 5'd0;
  localparam logic [4:0] OpAdd = 5'd1;
  localparam logic [4:0] OpSub = 5'd2;
  localparam logic [4:0] OpAnd = 5'd3;
  localparam logic [4:0] OpOr  = 5'd4;
  localparam logic [4:0] OpNot = 5'd5;
  localparam logic [4:0] OpXor = 5'd6;
  localparam logic [4:0] OpShl = 5'd7;
  localparam logic [4:0] OpShr = 5'd8;
  localparam logic [4:0] OpVal = 5'd9;
  localparam logic [4:0] OpCmp = 5'd10;
  localparam logic [4:0] OpMul = 5'd11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] opcode = '0;
  logic [7:0] operand1 = '0;
  logic [7:0] operand2 = '0;
  logic [7:0] param = '0;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic [5:0] status;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] res;
    logic [5:0] stat;
    int         at;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  alu_mc #(
    .DataWidth(8),
    .ParamBits(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .opcode  (opcode),
    .operand1(operand1),
    .operand2(operand2),
    .param   (param),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .status  (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_checks++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
    end
  endtask

  // Issue one operation, optionally re-asserting start while busy, and wait for the FSM to idle.
  task automatic apply_stimulus(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] p, input logic [7:0] exp_res,
                                input logic [5:0] exp_stat, input int lat, input bit poke);
    int busy_cycles;
    int guard;
    @(negedge clk);
    opcode   = op;
    operand1 = a;
    operand2 = b;
    param    = p;
    start    = 1'b1;
    exp_q.push_back('{res: exp_res, stat: exp_stat, at: cyc + lat});
    @(negedge clk);
    start    = poke;
    opcode   = poke ? OpAdd : op;
    operand1 = ~a;
    operand2 = a ^ b;
    param    = ~p;
    busy_cycles = 0;
    guard = 0;
    while (busy === 1'b1 && guard < 40) begin
      busy_cycles++;
      guard++;
      if (guard == 2) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    if (guard >= 40) check_output("busy timeout", {31'd0, busy}, 32'd0);
    check_output("busy cycles", busy_cycles, lat);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      check_output("spurious done", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check_output("result", {24'd0, result}, {24'd0, mon_e.res});
        check_output("status", {26'd0, status}, {26'd0, mon_e.stat});
        check_output("done cycle", cyc, mon_e.at);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Start held high while reset spans a clock edge must not be accepted.
    start    = 1'b1;
    opcode   = OpAdd;
    operand1 = 8'h11;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset done", {31'd0, done}, 32'd0);
    check_output("reset result", {24'd0, result}, 32'd0);
    check_output("reset status", {26'd0, status}, 32'd0);

    apply_stimulus(OpAdd, 8'd255, 8'd2,   8'd0,  8'h01, 6'b010001, 1, 1'b0);
    apply_stimulus(OpSub, 8'd14,  8'd15,  8'd0,  8'hFF, 6'b100010, 1, 1'b0);
    apply_stimulus(OpSub, 8'd126, 8'd126, 8'd0,  8'h00, 6'b001100, 1, 1'b0);
    apply_stimulus(OpAdd, 8'd128, 8'd128, 8'd0,  8'h00, 6'b001001, 1, 1'b0);
    apply_stimulus(OpAdd, 8'd0,   8'd0,   8'd0,  8'h00, 6'b001100, 1, 1'b0);
    apply_stimulus(OpAnd, 8'hF0,  8'h3C,  8'd0,  8'h30, 6'b010000, 1, 1'b0);
    apply_stimulus(OpOr,  8'h00,  8'h00,  8'd0,  8'h00, 6'b001100, 1, 1'b0);
    apply_stimulus(OpXor, 8'h55,  8'hAA,  8'd0,  8'hFF, 6'b100000, 1, 1'b0);
    apply_stimulus(OpNot, 8'h12,  8'hFF,  8'd0,  8'h00, 6'b000100, 1, 1'b0);
    apply_stimulus(OpVal, 8'h00,  8'h00,  8'hA5, 8'hA5, 6'b000000, 1, 1'b0);
    apply_stimulus(OpNop, 8'd5,   8'd5,   8'd3,  8'h00, 6'b000000, 1, 1'b0);
    apply_stimulus(5'd31, 8'd5,   8'd5,   8'd3,  8'h00, 6'b000000, 1, 1'b0);
    apply_stimulus(OpCmp, 8'hF6,  8'hF6,  8'd0,  8'h00, 6'b001000, 1, 1'b0);
    apply_stimulus(OpShl, 8'h06,  8'h00,  8'd3,  8'h30, 6'b000000, 4, 1'b0);
    apply_stimulus(OpShl, 8'h06,  8'h00,  8'd51, 8'h00, 6'b000100, 9, 1'b0);
    apply_stimulus(OpShl, 8'hFF,  8'h00,  8'd8,  8'h00, 6'b000100, 9, 1'b0);
    apply_stimulus(OpShr, 8'h80,  8'h00,  8'd7,  8'h01, 6'b000000, 8, 1'b0);
    apply_stimulus(OpShr, 8'h81,  8'h00,  8'd0,  8'h81, 6'b000000, 1, 1'b0);
    apply_stimulus(OpShr, 8'h80,  8'h00,  8'd4,  8'h08, 6'b000000, 5, 1'b1);
`ifdef ALU_MC_MUL_EN
    apply_stimulus(OpMul, 8'd16,  8'd20,  8'd0,  8'h40, 6'b000001, 9, 1'b0);
    apply_stimulus(OpMul, 8'd3,   8'd5,   8'd0,  8'h0F, 6'b000000, 9, 1'b0);
`else
    apply_stimulus(OpMul, 8'd16,  8'd20,  8'd0,  8'h00, 6'b000000, 1, 1'b0);
`endif

    // Reset in the middle of a shift must drop everything back to idle immediately.
    apply_stimulus(OpSub, 8'd14, 8'd15, 8'd0, 8'hFF, 6'b100010, 1, 1'b0);
    @(negedge clk);
    opcode   = OpShr;
    operand1 = 8'hF0;
    param    = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_output("busy mid shift", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check_output("mid reset busy", {31'd0, busy}, 32'd0);
    check_output("mid reset done", {31'd0, done}, 32'd0);
    check_output("mid reset result", {24'd0, result}, 32'd0);
    check_output("mid reset status", {26'd0, status}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(OpAdd, 8'd1, 8'd2, 8'd0, 8'h03, 6'b100000, 1, 1'b0);

    repeat (4) @(negedge clk);
    check_output("expectations drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
